// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port RAM arbiter: MEM-stage port with starvation-bounded debug read port
//
// Purpose:
//    Shares one synchronous single-port RAM between the pipeline MEM stage and a
//    debug/display read port. Grants are combinational in the request cycle.
//    MEM normally wins. A debug request that has been refused STARVE_MAX
//    consecutive cycles is then forced through. A small read-owner FSM routes the
//    RAM read data, which arrives one cycle after the grant, back to the port that
//    issued the read.
//
// Ports:
//    clk        in   1   clock, rising edge
//    rst        in   1   asynchronous active-high reset
//    mem_req    in   1   MEM access request, held until mem_gnt
//    mem_wen    in   4   MEM byte write enables, 0 = read
//    mem_addr   in  32   MEM byte address
//    mem_wdata  in  32   MEM write data, lane aligned
//    mem_gnt    out  1   MEM access issued this cycle
//    mem_rvalid out  1   MEM read data valid
//    mem_rdata  out 32   MEM read data
//    dbg_req    in   1   debug read request, held until dbg_gnt
//    dbg_addr   in  32   debug read byte address
//    dbg_gnt    out  1   debug read issued this cycle
//    dbg_rvalid out  1   debug read data valid
//    dbg_rdata  out 32   debug read data
//    ram_en     out  1   RAM enable
//    ram_wen    out  4   RAM byte write enables
//    ram_addr   out 32   RAM byte address
//    ram_wdata  out 32   RAM write data
//    ram_rdata  in  32   RAM read data, one cycle after a read

module dm_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req,
   input  logic [3:0]  mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_gnt,
   output logic        mem_rvalid,
   output logic [31:0] mem_rdata,
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   output logic        dbg_gnt,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic        ram_en,
   output logic [3:0]  ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_MEM = 2'd1,
      RD_DBG = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        mem_rvalid_q, dbg_rvalid_q;
   logic        dbg_force;
   logic        mem_gnt_c, dbg_gnt_c;

   // Grant decision. Reset masks both grants so nothing reaches the RAM while
   // rst is high, including a grant that would otherwise fall in that cycle.
   always_comb begin
      dbg_force = dbg_req && (starve_q == STARVE_LIM);
      mem_gnt_c = 1'b0;
      dbg_gnt_c = 1'b0;
      if (!rst) begin
         if (mem_req && !dbg_force) begin
            mem_gnt_c = 1'b1;
         end else if (dbg_req) begin
            dbg_gnt_c = 1'b1;
         end
      end
   end

   // Starvation counter: counts refused debug cycles, saturating at the limit.
   // Any cycle without a pending debug request, or with a debug grant, clears it.
   always_comb begin
      starve_d = starve_q;
      if (!dbg_req || dbg_gnt_c) begin
         starve_d = 4'd0;
      end else if (starve_q != STARVE_LIM) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // Read owner for the data returning next cycle. Writes need no return path.
   always_comb begin
      state_d = IDLE;
      if (mem_gnt_c && (mem_wen == 4'b0000)) begin
         state_d = RD_MEM;
      end else if (dbg_gnt_c) begin
         state_d = RD_DBG;
      end
   end

   // State, counter and registered rvalid flags. The flags are loaded from the
   // next state so they always agree with the registered read owner.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_q     <= 4'd0;
         mem_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         mem_rvalid_q <= (state_d == RD_MEM);
         dbg_rvalid_q <= (state_d == RD_DBG);
      end
   end

   assign mem_gnt    = mem_gnt_c;
   assign dbg_gnt    = dbg_gnt_c;
   assign mem_rvalid = mem_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;

   // Both read-data outputs see the RAM directly; the rvalid flags qualify them.
   assign mem_rdata  = ram_rdata;
   assign dbg_rdata  = ram_rdata;

   // RAM request mux. The debug port is read-only, so it never drives write lanes.
   always_comb begin
      ram_en    = mem_gnt_c | dbg_gnt_c;
      ram_wen   = 4'b0000;
      ram_addr  = 32'd0;
      ram_wdata = 32'd0;
      if (mem_gnt_c) begin
         ram_wen   = mem_wen;
         ram_addr  = mem_addr;
         ram_wdata = mem_wdata;
      end else if (dbg_gnt_c) begin
         ram_addr  = dbg_addr;
      end
   end

endmodule
